// File: rtl/simple_soc.sv
// Serial-echo SoC top: 8N1 UART receiver, one-byte holding register, 8N1 UART
// transmitter and an LED display register showing the last good byte.
module simple_soc #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] display_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

  // Receive path
  logic          r_rx_meta;
  logic          r_rxs;
  uart_state_t   r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_done;

  // Holding register, display and transmit path
  logic [7:0]    r_hold;
  logic          r_hold_valid;
  logic [7:0]    r_display;
  uart_state_t   r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_tx;
  logic          w_tx_load;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_state)
        ST_IDLE: begin
          if (!r_rxs) begin
            r_rx_state <= ST_START;
            r_rx_cnt   <= '0;
          end
        end
        ST_START: begin
          // Re-check the line mid start bit; a high level here was a glitch.
          if (r_rx_cnt == CNT_HALF) begin
            r_rx_cnt <= '0;
            if (!r_rxs) begin
              r_rx_state <= ST_DATA;
              r_rx_bit   <= '0;
            end else begin
              r_rx_state <= ST_IDLE;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rxs, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= ST_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= ST_IDLE;
            r_rx_done  <= r_rxs;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  // Loading from STOP as well as IDLE lets back-to-back echoes run gap-free.
  assign w_tx_load = r_hold_valid &&
                     ((r_tx_state == ST_IDLE) ||
                      ((r_tx_state == ST_STOP) && (r_tx_cnt == CNT_LAST)));

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_display    <= 8'h00;
      r_hold       <= 8'h00;
      r_hold_valid <= 1'b0;
    end else begin
      if (r_rx_done) begin
        r_display    <= r_rx_shift;
        r_hold       <= r_rx_shift;
        r_hold_valid <= 1'b1;
      end else if (w_tx_load) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_tx_load) begin
            r_tx_shift <= r_hold;
            r_tx_cnt   <= '0;
            r_tx_state <= ST_START;
            r_tx       <= 1'b0;
          end
        end
        ST_START: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= ST_DATA;
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= ST_STOP;
              r_tx       <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (w_tx_load) begin
              r_tx_shift <= r_hold;
              r_tx_state <= ST_START;
              r_tx       <= 1'b0;
            end else begin
              r_tx_state <= ST_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        default: begin
          r_tx_state <= ST_IDLE;
          r_tx       <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o      = r_tx;
  assign display_o = r_display;

endmodule

// File: tb/tb_simple_soc.sv
// Directed bench for simple_soc: drives 8N1 frames on rx_i, decodes tx_o with
// an independent line monitor and checks display/echo against fixed vectors.
module tb_simple_soc;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       tx_o;
  logic [7:0] display_o;

  int n_vec = 0;
  int n_err = 0;

  simple_soc #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset_i  (reset_i),
    .rx_i     (rx_i),
    .tx_o     (tx_o),
    .display_o(display_o)
  );

  always #5 clk = ~clk;

  // Line monitor: records 160 half-cycle-offset samples per transmitted frame.
  logic         m_busy = 1'b0;
  int           m_cnt = 0;
  int           m_starts = 0;
  logic [159:0] m_frame = '0;
  logic [159:0] m_last = '0;
  logic [7:0]   m_byte;
  logic [8:0]   m_q[$];

  always @(negedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (tx_o === 1'b0) begin
        m_busy    = 1'b1;
        m_frame[0] = tx_o;
        m_cnt     = 1;
        m_starts  = m_starts + 1;
      end
    end else begin
      m_frame[m_cnt] = tx_o;
      if (m_cnt == 159) begin
        m_busy = 1'b0;
        m_last = m_frame;
        for (int i = 0; i < 8; i++) m_byte[i] = m_frame[16*(i+1)+8];
        m_q.push_back({(m_frame[8] == 1'b0) && (m_frame[152] == 1'b1), m_byte});
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one frame; reports display_o as seen at the start of the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            output logic [7:0] disp_at_stop);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_i = bits[i];
      if (i == 9) disp_at_stop = display_o;
      repeat (CPB) @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 3000 && m_q.size() < n; i++) @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d_stop;
    logic [9:0] fb;
    logic       stable;
    int         starts0;

    // Reset and 200 idle cycles
    repeat (3) @(negedge clk);
    check("reset_display", 16'(display_o), 16'h00);
    check("reset_tx", 16'(tx_o), 16'h1);
    reset_i = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (display_o !== 8'h00 || tx_o !== 1'b1) stable = 1'b0;
    end
    check("idle_stable", 16'(stable), 16'h1);
    check("idle_no_tx_start", 16'(m_starts), 16'd0);

    // 0xA5: display timing and exact echo waveform
    m_q.delete();
    send_frame(8'hA5, 1'b1, d_stop);
    check("a5_disp_before_stop", 16'(d_stop), 16'h00);
    check("a5_display", 16'(display_o), 16'hA5);
    wait_frames(1);
    check("a5_echo_count", 16'(m_q.size()), 16'd1);
    fb = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++)
      check($sformatf("a5_tx_bit%0d", k), m_last[16*k +: 16], {16{fb[k]}});
    repeat (20) @(negedge clk);
    check("a5_tx_idle_after", 16'(tx_o), 16'h1);

    // 4-cycle glitch
    starts0 = m_starts;
    m_q.delete();
    @(negedge clk);
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_display", 16'(display_o), 16'hA5);
    check("glitch_no_echo", 16'(m_starts - starts0), 16'd0);
    check("glitch_tx_idle", 16'(tx_o), 16'h1);

    // Framing error on 0x3C, then valid 0x81
    send_frame(8'h3C, 1'b0, d_stop);
    repeat (200) @(negedge clk);
    check("ferr_display", 16'(display_o), 16'hA5);
    check("ferr_no_echo", 16'(m_starts - starts0), 16'd0);
    send_frame(8'h81, 1'b1, d_stop);
    check("x81_display", 16'(display_o), 16'h81);
    wait_frames(1);
    check("x81_echo_count", 16'(m_q.size()), 16'd1);
    check("x81_echo", 16'(m_q[0]), 16'h181);
    repeat (40) @(negedge clk);

    // Back-to-back 0x12, 0x34
    m_q.delete();
    send_frame(8'h12, 1'b1, d_stop);
    check("b2b_display_12", 16'(display_o), 16'h12);
    send_frame(8'h34, 1'b1, d_stop);
    check("b2b_disp_before_34", 16'(d_stop), 16'h12);
    check("b2b_display_34", 16'(display_o), 16'h34);
    wait_frames(2);
    check("b2b_echo_count", 16'(m_q.size()), 16'd2);
    check("b2b_echo_0", 16'(m_q[0]), 16'h112);
    check("b2b_echo_1", 16'(m_q[1]), 16'h134);
    repeat (40) @(negedge clk);

    // Reset in the middle of an echo, then 0x55
    send_frame(8'h77, 1'b1, d_stop);
    check("pre_reset_display", 16'(display_o), 16'h77);
    repeat (40) @(negedge clk);
    check("pre_reset_tx_busy", 16'(m_busy), 16'h1);
    #2 reset_i = 1'b1;
    #1;
    check("async_reset_tx", 16'(tx_o), 16'h1);
    check("async_reset_display", 16'(display_o), 16'h00);
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    m_q.delete();
    starts0 = m_starts;
    repeat (200) @(negedge clk);
    check("post_reset_tx", 16'(tx_o), 16'h1);
    check("post_reset_no_echo", 16'(m_starts - starts0), 16'd0);
    send_frame(8'h55, 1'b1, d_stop);
    check("x55_disp_before_stop", 16'(d_stop), 16'h00);
    check("x55_display", 16'(display_o), 16'h55);
    wait_frames(1);
    check("x55_echo_count", 16'(m_q.size()), 16'd1);
    check("x55_echo", 16'(m_q[0]), 16'h155);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
